// File: rtl/countdown_timer_core_if.sv
// Button and display bus between the timer core and its surroundings.
interface countdown_timer_core_if;
  localparam int unsigned TW = 6;

  logic          btn_min;
  logic          btn_sec;
  logic          btn_start;
  logic          btn_clear;
  logic [TW-1:0] min_out;
  logic [TW-1:0] sec_out;
  logic          running;
  logic          alarm;

  // Button source / display consumer side.
  modport master (
    output btn_min, btn_sec, btn_start, btn_clear,
    input  min_out, sec_out, running, alarm
  );

  // Timer core side.
  modport slave (
    input  btn_min, btn_sec, btn_start, btn_clear,
    output min_out, sec_out, running, alarm
  );
endinterface

// File: rtl/countdown_timer_core.sv
// Kitchen-timer countdown engine: MM:SS setpoint, 1 Hz countdown, timed alarm.
module countdown_timer_core #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_timer_core_if.slave bus
);
  localparam int unsigned TW     = 6;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACNT_W = $clog2(ALARM_SECS + 1);
  localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(TICK_DIV - 1);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_SECS - 1);
  localparam logic [TW-1:0]     MAX_VAL    = TW'(59);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     min_q, min_d;
  logic [TW-1:0]     sec_q, sec_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic              running_q, alarm_q;

  logic              tick_c;
  logic              time_nz_c;
  logic [PRE_W-1:0]  pre_inc_c;

  // State and datapath registers; running/alarm are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      pre_q     <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pre_q     <= pre_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_ALARM);
    end
  end

  // Next-state logic with priority clear > start > increments > tick.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pre_d     = pre_q;
    acnt_d    = acnt_q;
    tick_c    = (pre_q == PRE_MAX);
    time_nz_c = (min_q != '0) || (sec_q != '0);
    pre_inc_c = tick_c ? '0 : pre_q + PRE_W'(1);

    if (bus.btn_clear) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = '0;
      pre_d   = '0;
      acnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (bus.btn_start && time_nz_c) begin
            // A fresh start realigns the second; a resume keeps the frozen phase.
            state_d = S_RUN;
            if (state_q == S_IDLE) pre_d = '0;
          end else begin
            if (bus.btn_min) min_d = (min_q == MAX_VAL) ? '0 : min_q + TW'(1);
            if (bus.btn_sec) sec_d = (sec_q == MAX_VAL) ? '0 : sec_q + TW'(1);
          end
        end
        S_RUN: begin
          if (bus.btn_start) begin
            state_d = S_PAUSE;
          end else begin
            pre_d = pre_inc_c;
            if (tick_c) begin
              if (sec_q != '0) begin
                sec_d = sec_q - TW'(1);
              end else begin
                min_d = min_q - TW'(1);
                sec_d = MAX_VAL;
              end
              if (min_q == '0 && sec_q == TW'(1)) begin
                state_d = S_ALARM;
                acnt_d  = '0;
              end
            end
          end
        end
        S_ALARM: begin
          if (bus.btn_start) begin
            state_d = S_IDLE;
            acnt_d  = '0;
          end else begin
            pre_d = pre_inc_c;
            if (tick_c) begin
              if (acnt_q == ALARM_LAST) begin
                state_d = S_IDLE;
                acnt_d  = '0;
              end else begin
                acnt_d = acnt_q + ACNT_W'(1);
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.min_out = min_q;
  assign bus.sec_out = sec_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_countdown_timer_core.sv
// Randomized and directed bench for countdown_timer_core against a seconds-based model.
module tb_countdown_timer_core;
  localparam int TD = 4;
  localparam int AS = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  countdown_timer_core_if bus_if ();

  countdown_timer_core #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining time handled as a plain count of seconds.
  int m_mode, m_min, m_sec, m_pre, m_acnt;

  function automatic void model_rst();
    m_mode = M_IDLE; m_min = 0; m_sec = 0; m_pre = 0; m_acnt = 0;
  endfunction

  function automatic void model_step(input bit bm, input bit bs, input bit bst, input bit bc);
    int rem;
    bit tick;
    rem  = m_min * 60 + m_sec;
    tick = (m_pre == TD - 1);
    if (bc) begin
      m_mode = M_IDLE; m_min = 0; m_sec = 0; m_pre = 0; m_acnt = 0;
    end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
      if (bst && rem != 0) begin
        if (m_mode == M_IDLE) m_pre = 0;
        m_mode = M_RUN;
      end else begin
        if (bm) m_min = (m_min + 1) % 60;
        if (bs) m_sec = (m_sec + 1) % 60;
      end
    end else if (m_mode == M_RUN) begin
      if (bst) m_mode = M_PAUSE;
      else begin
        m_pre = (m_pre + 1) % TD;
        if (tick) begin
          rem   = rem - 1;
          m_min = rem / 60;
          m_sec = rem % 60;
          if (rem == 0) begin m_mode = M_ALARM; m_acnt = 0; end
        end
      end
    end else begin
      if (bst) m_mode = M_IDLE;
      else begin
        m_pre = (m_pre + 1) % TD;
        if (tick) begin
          m_acnt = m_acnt + 1;
          if (m_acnt == AS) m_mode = M_IDLE;
        end
      end
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    return {6'(m_min), 6'(m_sec), (m_mode == M_RUN), (m_mode == M_ALARM)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus_if.min_out, bus_if.sec_out, bus_if.running, bus_if.alarm};
  endfunction

  // One clock cycle with the given button pulses; model follows the same edge.
  task automatic drive(input bit bm, input bit bs, input bit bst, input bit bc);
    bus_if.btn_min = bm; bus_if.btn_sec = bs; bus_if.btn_start = bst; bus_if.btn_clear = bc;
    @(posedge clk);
    if (!reset) model_rst();
    else model_step(bm, bs, bst, bc);
    #1;
    bus_if.btn_min = 1'b0; bus_if.btn_sec = 1'b0; bus_if.btn_start = 1'b0; bus_if.btn_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      total++;
      if (dut_vec() !== 14'h0) begin
        bad++; $display("FAIL reset_hold: got %h want %h", dut_vec(), 14'h0);
      end
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== 14'h0 || exp_vec() !== 14'h0) begin
      bad++; $display("FAIL reset_release: got %h want %h", dut_vec(), 14'h0);
    end
  endtask

  task automatic test_setting();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd3, 6'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL set_0301: got %h want %h", dut_vec(), {6'd3, 6'd1, 2'b00});
    end
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd3, 6'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL min_wrap: got %h want %h", dut_vec(), {6'd3, 6'd1, 2'b00});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== exp_vec() || bus_if.min_out !== 6'd4 || bus_if.sec_out !== 6'd2) begin
      bad++; $display("FAIL both_inc: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_countdown();
    int n;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd1, 6'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL cd_pre_tick: got %h want %h", dut_vec(), {6'd1, 6'd1, 2'b10});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd1, 6'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL cd_first: got %h want %h", dut_vec(), {6'd1, 6'd0, 2'b10});
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd59, 1'b1, 1'b0}) begin
      bad++; $display("FAIL cd_borrow: got %h want %h", dut_vec(), {6'd0, 6'd59, 2'b10});
    end
    n = 0;
    while (n < 400 && bus_if.alarm !== 1'b1) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL cd_track: got %h want %h", dut_vec(), exp_vec());
      end
    end
    total++;
    if (n != 59 * TD || dut_vec() !== {6'd0, 6'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL cd_alarm: got %h after %0d cycles want %h after %0d", dut_vec(), n, {12'd0, 2'b01}, 59 * TD);
    end
  endtask

  task automatic test_pause();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd9, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pause_frozen: got %h want %h", dut_vec(), {6'd0, 6'd9, 2'b00});
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd9, 1'b1, 1'b0}) begin
      bad++; $display("FAIL resume_early: got %h want %h", dut_vec(), {6'd0, 6'd9, 2'b10});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd8, 1'b1, 1'b0}) begin
      bad++; $display("FAIL resume_dec: got %h want %h", dut_vec(), {6'd0, 6'd8, 2'b10});
    end
    for (int i = 0; i < TD - 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd8, 1'b0, 1'b0} || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL pause_on_tick: got %h want %h", dut_vec(), {6'd0, 6'd8, 2'b00});
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL resume_after_tick: got %h want %h", dut_vec(), {6'd0, 6'd7, 2'b10});
    end
  endtask

  task automatic test_alarm_exit();
    int n;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TD; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {12'd0, 2'b01}) begin
      bad++; $display("FAIL alarm_enter: got %h want %h", dut_vec(), {12'd0, 2'b01});
    end
    n = 0;
    while (n < 40 && bus_if.alarm === 1'b1) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (n != AS * TD || dut_vec() !== 14'h0) begin
      bad++; $display("FAIL alarm_auto: got %h after %0d cycles want %h after %0d", dut_vec(), n, 14'h0, AS * TD);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TD + 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (dut_vec() !== 14'h0 || exp_vec() !== 14'h0) begin
      bad++; $display("FAIL alarm_ack: got %h want %h", dut_vec(), 14'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd1, 2'b00}) begin
      bad++; $display("FAIL alarm_ack_idle: got %h want %h", dut_vec(), {6'd0, 6'd1, 2'b00});
    end
  endtask

  task automatic test_corners();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (dut_vec() !== 14'h0) begin
      bad++; $display("FAIL start_at_zero: got %h want %h", dut_vec(), 14'h0);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (dut_vec() !== {6'd0, 6'd5, 2'b10}) begin
      bad++; $display("FAIL start_with_sec: got %h want %h", dut_vec(), {6'd0, 6'd5, 2'b10});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (dut_vec() !== 14'h0) begin
      bad++; $display("FAIL clear_start_run: got %h want %h", dut_vec(), 14'h0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 14'h0) begin
      bad++; $display("FAIL async_reset: got %h want %h", dut_vec(), 14'h0);
    end
    model_rst();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (dut_vec() !== 14'h0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL post_reset: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit bm, bs, bst, bc;
    for (int i = 0; i < 4000; i++) begin
      bm  = ($urandom_range(0, 5) == 0);
      bs  = ($urandom_range(0, 3) == 0);
      bst = ($urandom_range(0, 40) == 0);
      bc  = ($urandom_range(0, 400) == 0);
      drive(bm, bs, bst, bc);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_if.btn_min = 1'b0; bus_if.btn_sec = 1'b0; bus_if.btn_start = 1'b0; bus_if.btn_clear = 1'b0;
    model_rst();
    test_reset();
    test_setting();
    test_countdown();
    test_pause();
    test_alarm_exit();
    test_corners();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
